// File: rtl/imem_loader.sv
`timescale 1ns/1ps
// imem_loader
// Boot-time owner of the instruction RAM write port. Holds the core in stall
// while a byte stream (4-byte LE word count N, N LE words, optional checksum
// byte) is received, writes each assembled word to BASE_ADDR + 4*idx, then
// releases the core.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   -> trailing XOR checksum byte required (CHK state present)
//   undefined -> no checksum; the last word (or N == 0) goes straight to FLUSH
//
// Ports
//   clk, rst_n         : clock (rising edge), async active-low reset
//   rx_valid/rx_data   : incoming stream byte
//   rx_ready           : byte accepted this cycle when rx_valid && rx_ready
//   load_start         : pulse, restarts a load from DONE or ERR
//   is_write           : one-cycle RAM write strobe per word
//   im_addr / im_inst  : RAM byte address / word for the write
//   cpu_hold           : core held while high
//   load_done/load_err : terminal status flags (never both high)
//   dbg_state          : current FSM state encoding
//
// Handshake: a byte transfers on the rising edge where rx_valid && rx_ready;
// rx_ready depends only on the state, never on rx_valid.
module imem_loader #(
  parameter int          W         = 32,
  parameter int          DEPTH     = 2048,
  parameter logic [W-1:0] BASE_ADDR = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         rx_ready,
  input  logic         load_start,
  output logic         is_write,
  output logic [W-1:0] im_addr,
  output logic [W-1:0] im_inst,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err,
  output logic [2:0]   dbg_state
);

  localparam int IW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_CHK   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_FLUSH;
`endif

  state_t        r_state;
  logic [W-1:0]  r_len;
  logic [W-1:0]  r_word;
  logic [1:0]    r_byte_cnt;
  logic [IW-1:0] r_idx;
  logic          r_is_write;
  logic [W-1:0]  r_im_addr;
  logic [W-1:0]  r_im_inst;
  logic          r_cpu_hold;
  logic          r_load_done;
  logic          r_load_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    r_csum;
`endif

  logic          w_accept;
  logic          w_last_byte;
  logic [W-1:0]  w_len_next;
  logic [W-1:0]  w_word_next;
  logic [IW-1:0] w_idx_inc;
  logic [W-1:0]  w_addr;

  assign rx_ready    = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_accept    = rx_valid && rx_ready;
  assign w_last_byte = (r_byte_cnt == 2'd3);
  // Little-endian assembly: each new byte enters at the top and shifts down,
  // so after four bytes the first one sits in bits [7:0].
  assign w_len_next  = {rx_data, r_len[W-1:8]};
  assign w_word_next = {rx_data, r_word[W-1:8]};
  assign w_idx_inc   = r_idx + IW'(1);
  assign w_addr      = BASE_ADDR + (W'(r_idx) << 2);

  assign is_write  = r_is_write;
  assign im_addr   = r_im_addr;
  assign im_inst   = r_im_inst;
  assign cpu_hold  = r_cpu_hold;
  assign load_done = r_load_done;
  assign load_err  = r_load_err;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_LEN;
      r_len       <= '0;
      r_word      <= '0;
      r_byte_cnt  <= '0;
      r_idx       <= '0;
      r_is_write  <= 1'b0;
      r_im_addr   <= BASE_ADDR;
      r_im_inst   <= '0;
      r_cpu_hold  <= 1'b1;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_is_write <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      // Running XOR covers length and data bytes; the checksum byte itself
      // is compared against it, not folded in.
      if (w_accept && (r_state != S_CHK)) r_csum <= r_csum ^ rx_data;
`endif
      case (r_state)
        S_LEN: begin
          if (w_accept) begin
            r_len      <= w_len_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              if (w_len_next > W'(DEPTH)) begin
                r_state    <= S_ERR;
                r_load_err <= 1'b1;
              end else if (w_len_next == '0) begin
                r_state <= S_TAIL;
              end else begin
                r_state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word     <= w_word_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_im_inst  <= w_word_next;
              r_im_addr  <= w_addr;
              r_is_write <= 1'b1;
              r_idx      <= w_idx_inc;
              if (W'(w_idx_inc) == r_len) r_state <= S_TAIL;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (w_accept) begin
            if (rx_data == r_csum) begin
              r_state <= S_FLUSH;
            end else begin
              r_state    <= S_ERR;
              r_load_err <= 1'b1;
            end
          end
        end
`endif
        S_FLUSH: begin
          // One idle cycle so the final write strobe has retired before
          // the core is released.
          r_state     <= S_DONE;
          r_cpu_hold  <= 1'b0;
          r_load_done <= 1'b1;
        end
        S_DONE, S_ERR: begin
          if (load_start) begin
            r_state     <= S_LEN;
            r_len       <= '0;
            r_word      <= '0;
            r_byte_cnt  <= '0;
            r_idx       <= '0;
            r_cpu_hold  <= 1'b1;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum      <= '0;
`endif
          end
        end
        default: begin
          r_state <= S_ERR;
          r_load_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_ready;
  logic         load_start = 1'b0;
  logic         is_write;
  logic [W-1:0] im_addr;
  logic [W-1:0] im_inst;
  logic         cpu_hold;
  logic         load_done;
  logic         load_err;
  logic [2:0]   dbg_state;

  imem_loader #(.W(W), .DEPTH(2048), .BASE_ADDR(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .load_start (load_start),
    .is_write   (is_write),
    .im_addr    (im_addr),
    .im_inst    (im_inst),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: expected writes as {addr, inst}
  logic [2*W-1:0] exp_q[$];
  logic [7:0]     stim_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor: pops one expected write per is_write cycle
  logic prev_write = 1'b0;
  always @(negedge clk) begin
    if (rst_n && is_write) begin
      check("write_single_cycle", {63'd0, prev_write}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h/%h expected=none", im_addr, im_inst);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("write", {im_addr, im_inst}, e);
      end
    end
    prev_write <= rst_n && is_write;
  end

  // driver tasks (all called at #1 after a rising edge)
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (!rx_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout actual=0 expected=1");
    end else begin
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_stim(input int max_gap);
    while (stim_q.size() > 0) send_byte(stim_q.pop_front(), $urandom_range(0, max_gap));
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(load_done || load_err) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL end_timeout actual=running expected=done_or_err");
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 load_start = 1'b1;
    @(posedge clk); #1 load_start = 1'b0;
  endtask

  task automatic push_image_a(input logic [7:0] csum);
    stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.push_back(csum);
`else
    if (csum == 8'hff) stim_q.push_back(csum);
`endif
    exp_q.push_back({32'h0, 32'h00000013});
    exp_q.push_back({32'h4, 32'h00100093});
  endtask

  task automatic check_status(input string tag, input logic done, input logic err,
                              input logic hold, input logic rdy);
    check({tag, "_load_done"}, {63'd0, load_done}, {63'd0, done});
    check({tag, "_load_err"},  {63'd0, load_err},  {63'd0, err});
    check({tag, "_cpu_hold"},  {63'd0, cpu_hold},  {63'd0, hold});
    check({tag, "_rx_ready"},  {63'd0, rx_ready},  {63'd0, rdy});
    check({tag, "_drained"},   64'(exp_q.size()),  64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_is_write"}, {63'd0, is_write}, 64'd0);
    check({tag, "_im_addr"},  64'(im_addr),      64'd0);
    check({tag, "_im_inst"},  64'(im_inst),      64'd0);
    check({tag, "_cpu_hold"}, {63'd0, cpu_hold}, 64'd1);
    check({tag, "_load_done"},{63'd0, load_done},64'd0);
    check({tag, "_load_err"}, {63'd0, load_err}, 64'd0);
  endtask

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1 check_reset_values("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rx_ready", {63'd0, rx_ready}, 64'd1);

    // image A with correct checksum
    push_image_a(8'h92);
    send_stim(0);
    wait_end();
    check_status("imgA", 1'b1, 1'b0, 1'b0, 1'b0);

    // restart from DONE
    pulse_start();
    check("restart_cpu_hold", {63'd0, cpu_hold}, 64'd1);
    check("restart_load_done", {63'd0, load_done}, 64'd0);
    check("restart_rx_ready", {63'd0, rx_ready}, 64'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // same image, wrong checksum: writes happen, load ends in ERR
    push_image_a(8'h00);
    send_stim(1);
    wait_end();
    check_status("badchk", 1'b0, 1'b1, 1'b1, 1'b0);
`else
    // one-word image overwriting address 0
    stim_q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back({32'h0, 32'hDEADBEEF});
    send_stim(1);
    wait_end();
    check_status("img1", 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    // length 2049 is too large
    pulse_start();
    stim_q = '{8'h01, 8'h08, 8'h00, 8'h00};
    send_stim(0);
    wait_end();
    check_status("toolong", 1'b0, 1'b1, 1'b1, 1'b0);

    // empty image
    pulse_start();
    stim_q = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stim_q.push_back(8'h00);
`endif
    send_stim(0);
    wait_end();
    check_status("empty", 1'b1, 1'b0, 1'b0, 1'b0);

    // reset after 6 bytes of a 2-word load
    pulse_start();
    stim_q = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00};
    send_stim(3);
    rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    check("midrst_rx_ready", {63'd0, rx_ready}, 64'd1);

    // fresh full stream with gaps; a load_start mid-stream must be ignored
    push_image_a(8'h92);
    for (int i = 0; i < 5; i++) send_byte(stim_q.pop_front(), $urandom_range(0, 3));
    pulse_start();
    send_stim(3);
    wait_end();
    check_status("reload", 1'b1, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // never both status flags together
  always @(negedge clk) begin
    if (load_done && load_err) begin
      checks++;
      errors++;
      $display("FAIL done_and_err actual=11 expected=not_both");
    end
  end

endmodule
